sd_card_responder: RTL

// SPI-mode SD card responder: the card side of the SD init/command link. Deframes 48-bit

---
 rtl/sd_card_responder_if.sv | 28 ++
 rtl/sd_card_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_card_responder_if.sv
// SPI-mode SD link between an init master and the card responder.
// The master drives chip select and MOSI; the card drives MISO and status.
interface sd_card_responder_if;
    logic       SD_cs;
    logic       SD_datain;
    logic       SD_dataout;
    logic       card_ready;
    logic       cmd_valid;
    logic [5:0] cmd_index;

    modport master (
        output SD_cs,
        output SD_datain,
        input  SD_dataout,
        input  card_ready,
        input  cmd_valid,
        input  cmd_index
    );

    modport slave (
        input  SD_cs,
        input  SD_datain,
        output SD_dataout,
        output card_ready,
        output cmd_valid,
        output cmd_index
    );
endinterface

// File: rtl/sd_card_responder.sv
// SPI-mode SD card responder. Deframes 48-bit commands sampled on the rising
// edge of SD_clk and answers with R1/R3/R7 shifted out on the falling edge.
// Models the CMD0 -> CMD8 -> (CMD55+ACMD41)xN -> CMD58 -> CMD16 power-up flow.
module sd_card_responder #(
    parameter int SDHC        = 1,
    parameter int ACMD41_BUSY = 3,
    parameter int NCR_BYTES   = 1
) (
    input logic            SD_clk,
    input logic            rst_n,
    sd_card_responder_if.slave sd
);

    typedef enum logic [1:0] {HUNT, CMD, NCR, RESP} state_t;

    localparam logic [5:0] NCR_LAST  = 6'(NCR_BYTES * 8 - 1);
    localparam logic [3:0] BUSY_LIM  = 4'(ACMD41_BUSY);
    localparam logic [5:0] LAST_BIT  = 6'd47;
    localparam logic [5:0] R1_LAST   = 6'd7;
    localparam logic [5:0] LONG_LAST = 6'd39;

    state_t      state_reg,      state_next;
    logic [5:0]  bit_cnt_reg,    bit_cnt_next;
    logic [46:0] shift_reg,      shift_next;
    logic [5:0]  ncr_cnt_reg,    ncr_cnt_next;
    logic [39:0] resp_reg,       resp_next;
    logic [5:0]  resp_last_reg,  resp_last_next;
    logic        in_idle_reg,    in_idle_next;
    logic        app_cmd_reg,    app_cmd_next;
    logic [3:0]  busy_cnt_reg,   busy_cnt_next;
    logic        card_ready_reg, card_ready_next;
    logic        cmd_valid_reg,  cmd_valid_next;
    logic [5:0]  cmd_index_reg,  cmd_index_next;
    logic        dataout_reg;

    // Full frame as seen on the posedge that samples the final (end) bit.
    logic [47:0] frame;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        crc_ok;

    // Generator x^7 + x^3 + 1, MSB first, zero preset.
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    assign frame  = {shift_reg, sd.SD_datain};
    assign idx    = frame[45:40];
    assign arg    = frame[39:8];
    assign crc_ok = (frame[7:1] == crc7(frame[47:8]));

    // Posedge state: FSM, frame shifter, response sequencing and card state.
    always_ff @(posedge SD_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= HUNT;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            ncr_cnt_reg    <= '0;
            resp_reg       <= '0;
            resp_last_reg  <= '0;
            in_idle_reg    <= 1'b1;
            app_cmd_reg    <= 1'b0;
            busy_cnt_reg   <= '0;
            card_ready_reg <= 1'b0;
            cmd_valid_reg  <= 1'b0;
            cmd_index_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            ncr_cnt_reg    <= ncr_cnt_next;
            resp_reg       <= resp_next;
            resp_last_reg  <= resp_last_next;
            in_idle_reg    <= in_idle_next;
            app_cmd_reg    <= app_cmd_next;
            busy_cnt_reg   <= busy_cnt_next;
            card_ready_reg <= card_ready_next;
            cmd_valid_reg  <= cmd_valid_next;
            cmd_index_reg  <= cmd_index_next;
        end
    end

    // Next-state: hunt for start bit, collect 48 bits, decode, then NCR fill and response.
    always_comb begin
        logic [7:0]  r1;
        logic [31:0] body;
        logic        long_resp;

        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        ncr_cnt_next    = ncr_cnt_reg;
        resp_next       = resp_reg;
        resp_last_next  = resp_last_reg;
        in_idle_next    = in_idle_reg;
        app_cmd_next    = app_cmd_reg;
        busy_cnt_next   = busy_cnt_reg;
        card_ready_next = card_ready_reg;
        cmd_valid_next  = 1'b0;
        cmd_index_next  = cmd_index_reg;
        r1              = 8'h00;
        body            = 32'h0;
        long_resp       = 1'b0;

        if (sd.SD_cs) begin
            // Deselect abandons any frame or response; card state is kept.
            state_next = HUNT;
        end else begin
            case (state_reg)
                HUNT: begin
                    shift_next = {shift_reg[45:0], sd.SD_datain};
                    if (!sd.SD_datain) begin
                        state_next   = CMD;
                        bit_cnt_next = 6'd1;
                    end
                end
                CMD: begin
                    shift_next   = {shift_reg[45:0], sd.SD_datain};
                    bit_cnt_next = bit_cnt_reg + 6'd1;
                    if (bit_cnt_reg == 6'd1 && !sd.SD_datain) begin
                        // Transmission bit must be 1; otherwise keep hunting.
                        state_next = HUNT;
                    end else if (bit_cnt_reg == LAST_BIT) begin
                        if (!sd.SD_datain) begin
                            state_next = HUNT;
                        end else begin
                            cmd_valid_next = 1'b1;
                            cmd_index_next = idx;
                            app_cmd_next   = 1'b0;
                            if ((idx == 6'd0 || idx == 6'd8) && !crc_ok) begin
                                r1 = {4'b0000, 1'b1, 2'b00, in_idle_reg};
                            end else begin
                                case (idx)
                                    6'd0: begin
                                        in_idle_next    = 1'b1;
                                        card_ready_next = 1'b0;
                                        busy_cnt_next   = '0;
                                        r1              = 8'h01;
                                    end
                                    6'd8: begin
                                        long_resp = 1'b1;
                                        r1        = {7'b0, in_idle_reg};
                                        body      = {20'h0, (arg[11:8] == 4'h1) ? 4'h1 : 4'h0, arg[7:0]};
                                    end
                                    6'd55: begin
                                        r1           = {7'b0, in_idle_reg};
                                        app_cmd_next = 1'b1;
                                    end
                                    6'd41: begin
                                        if (app_cmd_reg) begin
                                            if (busy_cnt_reg < BUSY_LIM) begin
                                                r1            = 8'h01;
                                                busy_cnt_next = (busy_cnt_reg == 4'hF) ? 4'hF : busy_cnt_reg + 4'd1;
                                            end else begin
                                                r1              = 8'h00;
                                                in_idle_next    = 1'b0;
                                                card_ready_next = 1'b1;
                                            end
                                        end else begin
                                            r1 = {5'b0, 1'b1, 1'b0, in_idle_reg};
                                        end
                                    end
                                    6'd58: begin
                                        long_resp = 1'b1;
                                        r1        = {7'b0, in_idle_reg};
                                        body      = {card_ready_reg, (SDHC != 0) && card_ready_reg,
                                                     6'b0, 9'h1FF, 15'h0};
                                    end
                                    6'd16: begin
                                        r1 = (arg == 32'd512) ? {7'b0, in_idle_reg}
                                                              : {1'b0, 1'b1, 5'b0, in_idle_reg};
                                    end
                                    default: begin
                                        r1 = {5'b0, 1'b1, 1'b0, in_idle_reg};
                                    end
                                endcase
                            end
                            resp_next      = {r1, body};
                            resp_last_next = long_resp ? LONG_LAST : R1_LAST;
                            ncr_cnt_next   = '0;
                            state_next     = NCR;
                        end
                    end
                end
                NCR: begin
                    if (ncr_cnt_reg == NCR_LAST) begin
                        state_next   = RESP;
                        bit_cnt_next = '0;
                    end else begin
                        ncr_cnt_next = ncr_cnt_reg + 6'd1;
                    end
                end
                RESP: begin
                    resp_next = {resp_reg[38:0], 1'b0};
                    if (bit_cnt_reg == resp_last_reg) begin
                        state_next = HUNT;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 6'd1;
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    // Negedge MISO driver: response MSB while responding, idle-high otherwise.
    always_ff @(negedge SD_clk or negedge rst_n) begin
        if (!rst_n) begin
            dataout_reg <= 1'b1;
        end else begin
            dataout_reg <= (state_reg == RESP) ? resp_reg[39] : 1'b1;
        end
    end

    assign sd.SD_dataout = dataout_reg;
    assign sd.card_ready = card_ready_reg;
    assign sd.cmd_valid  = cmd_valid_reg;
    assign sd.cmd_index  = cmd_index_reg;

endmodule
